signed_multiplier_pipe: RTL and testbench

Parametrised, pipelined signed multiply / multiply-accumulate unit for the Reed-Solomon datapath. It generalises the fixed 15x9 signed multiplier to configurable operand widths, output width and pipeline depth. It adds a valid/clock-enable pipeline, optional round-half-up scaling of the product, and a per-sample accumulate mode with saturation and an overflow flag.

---
 rtl/signed_multiplier_pipe.sv | 150 +++++++++++++++
 tb/tb_signed_multiplier_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/signed_multiplier_pipe.sv
// Pipelined signed multiply / multiply-accumulate with optional round-half-up
// scaling, saturating accumulation and an overflow flag.
module signed_multiplier_pipe #(
    parameter int A_WIDTH   = 15,
    parameter int B_WIDTH   = 9,
    parameter int OUT_WIDTH = 24,
    parameter int LATENCY   = 3,
    parameter int ROUND     = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic signed [A_WIDTH-1:0]   dataa,
    input  logic signed [B_WIDTH-1:0]   datab,
    input  logic                        acc,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] result,
    output logic                        overflow
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int SHIFT   = P_WIDTH - OUT_WIDTH;
    localparam int MID     = LATENCY - 2;

    localparam logic signed [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // Stage 1: operand capture
    logic                      s1_valid;
    logic                      s1_acc;
    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (ce) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: data registers carry no reset; the valid bits alone decide whether they matter.
    always_ff @(posedge clock) begin
        if (ce) begin
            a_q    <= dataa;
            b_q    <= datab;
            s1_acc <= acc;
        end
    end

    // Exact product, then scaling to OUT_WIDTH
    logic signed [P_WIDTH-1:0] product;
    logic signed [P_WIDTH:0]   product_ext;
    logic signed [P_WIDTH:0]   rounded;
    logic signed [OUT_WIDTH-1:0] scaled;

    assign product     = $signed({{B_WIDTH{a_q[A_WIDTH-1]}}, a_q}) *
                         $signed({{A_WIDTH{b_q[B_WIDTH-1]}}, b_q});
    assign product_ext = $signed({product[P_WIDTH-1], product});

    generate
        if (ROUND != 0 && SHIFT > 0) begin : g_round
            localparam logic signed [P_WIDTH:0] HALF = {{P_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
            assign rounded = product_ext + HALF;
        end else begin : g_trunc
            assign rounded = product_ext;
        end
    endgenerate

    // The extra headroom bit guarantees the scaled value fits OUT_WIDTH.
    assign scaled = OUT_WIDTH'(rounded >>> SHIFT);

    // Intermediate stages carry the scaled product with its valid/acc bits
    logic                        fin_valid;
    logic                        fin_acc;
    logic signed [OUT_WIDTH-1:0] fin_s;

    generate
        if (MID == 0) begin : g_direct
            assign fin_valid = s1_valid;
            assign fin_acc   = s1_acc;
            assign fin_s     = scaled;
        end else begin : g_mid
            logic [MID-1:0]              mid_valid;
            logic [MID-1:0]              mid_acc;
            logic signed [OUT_WIDTH-1:0] mid_s [MID];

            always_ff @(posedge clock) begin
                if (reset) begin
                    mid_valid <= '0;
                end else if (ce) begin
                    mid_valid[0] <= s1_valid;
                    for (int i = 1; i < MID; i++) mid_valid[i] <= mid_valid[i-1];
                end
            end

            always_ff @(posedge clock) begin
                if (ce) begin
                    mid_acc[0] <= s1_acc;
                    mid_s[0]   <= scaled;
                    for (int i = 1; i < MID; i++) begin
                        mid_acc[i] <= mid_acc[i-1];
                        mid_s[i]   <= mid_s[i-1];
                    end
                end
            end

            assign fin_valid = mid_valid[MID-1];
            assign fin_acc   = mid_acc[MID-1];
            assign fin_s     = mid_s[MID-1];
        end
    endgenerate

    // Final stage: load or saturating accumulate
    logic signed [OUT_WIDTH:0]   sum;
    logic signed [OUT_WIDTH-1:0] next_result;
    logic                        next_overflow;

    assign sum = $signed({result[OUT_WIDTH-1], result}) + $signed({fin_s[OUT_WIDTH-1], fin_s});

    // NOTE: combinational logic uses blocking assignments with defaults first, so no latch is inferred.
    always_comb begin
        next_result   = result;
        next_overflow = 1'b0;
        if (fin_valid) begin
            if (!fin_acc) begin
                next_result = fin_s;
            end else if (sum[OUT_WIDTH] != sum[OUT_WIDTH-1]) begin
                next_result   = sum[OUT_WIDTH] ? MIN_NEG : MAX_POS;
                next_overflow = 1'b1;
            end else begin
                next_result = sum[OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (ce) begin
            result    <= next_result;
            out_valid <= fin_valid;
            overflow  <= next_overflow;
        end
    end

endmodule

// File: tb/tb_signed_multiplier_pipe.sv
// Self-checking bench: three configurations share one stimulus stream and are
// compared every clock against a sample-history reference model.
module tb_signed_multiplier_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b0;
    logic        in_valid = 1'b0;
    logic [14:0] dataa = '0;
    logic [8:0]  datab = '0;
    logic        acc = 1'b0;

    logic               vld0, vld1, vld2;
    logic               ovf0, ovf1, ovf2;
    logic signed [23:0] res0;
    logic signed [15:0] res1, res2;

    always #5 clock = ~clock;

    signed_multiplier_pipe #(.A_WIDTH(15), .B_WIDTH(9), .OUT_WIDTH(24), .LATENCY(3), .ROUND(0)) dut_main (
        .clock(clock), .reset(reset), .ce(ce), .in_valid(in_valid), .dataa(dataa), .datab(datab),
        .acc(acc), .out_valid(vld0), .result(res0), .overflow(ovf0));

    signed_multiplier_pipe #(.A_WIDTH(15), .B_WIDTH(9), .OUT_WIDTH(16), .LATENCY(2), .ROUND(1)) dut_rnd (
        .clock(clock), .reset(reset), .ce(ce), .in_valid(in_valid), .dataa(dataa), .datab(datab),
        .acc(acc), .out_valid(vld1), .result(res1), .overflow(ovf1));

    signed_multiplier_pipe #(.A_WIDTH(15), .B_WIDTH(9), .OUT_WIDTH(16), .LATENCY(4), .ROUND(0)) dut_trn (
        .clock(clock), .reset(reset), .ce(ce), .in_valid(in_valid), .dataa(dataa), .datab(datab),
        .acc(acc), .out_valid(vld2), .result(res2), .overflow(ovf2));

    typedef struct {
        logic   v;
        longint a;
        longint b;
        logic   ac;
    } sample_t;

    int     tests = 0;
    int     fails = 0;
    int     lat[3] = '{3, 2, 4};
    int     ow[3]  = '{24, 16, 16};
    int     rnd[3] = '{0, 1, 0};
    longint cur_a, cur_b;
    sample_t hist[$];
    longint exp_res[3];
    logic   exp_vld[3];
    logic   exp_ov[3];

    task automatic check(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Apply one sample at the output of configuration i using plain integer arithmetic.
    task automatic apply(input int i, input sample_t s);
        longint p, t, maxv, minv;
        int sh;
        if (!s.v) begin
            exp_vld[i] = 1'b0;
            exp_ov[i]  = 1'b0;
            return;
        end
        sh = 24 - ow[i];
        p  = s.a * s.b;
        if (rnd[i] != 0 && sh > 0) p = p + (longint'(1) << (sh - 1));
        p    = p >>> sh;
        maxv = (longint'(1) << (ow[i] - 1)) - 1;
        minv = -maxv - 1;
        exp_vld[i] = 1'b1;
        exp_ov[i]  = 1'b0;
        if (!s.ac) begin
            exp_res[i] = p;
        end else begin
            t = exp_res[i] + p;
            if (t > maxv) begin
                exp_res[i] = maxv;
                exp_ov[i]  = 1'b1;
            end else if (t < minv) begin
                exp_res[i] = minv;
                exp_ov[i]  = 1'b1;
            end else begin
                exp_res[i] = t;
            end
        end
    endtask

    // A sample accepted at ce-edge n emerges at ce-edge n+LATENCY-1 of the history.
    task automatic model_edge();
        if (reset) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                exp_res[i] = 0;
                exp_vld[i] = 1'b0;
                exp_ov[i]  = 1'b0;
            end
        end else if (ce) begin
            hist.push_back('{in_valid, cur_a, cur_b, acc});
            for (int i = 0; i < 3; i++) begin
                if (hist.size() >= lat[i]) begin
                    apply(i, hist[hist.size() - lat[i]]);
                end else begin
                    exp_vld[i] = 1'b0;
                    exp_ov[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("vld_main", longint'(vld0), longint'(exp_vld[0]));
        check("res_main", longint'(res0), exp_res[0]);
        check("ovf_main", longint'(ovf0), longint'(exp_ov[0]));
        check("vld_rnd",  longint'(vld1), longint'(exp_vld[1]));
        check("res_rnd",  longint'(res1), exp_res[1]);
        check("ovf_rnd",  longint'(ovf1), longint'(exp_ov[1]));
        check("vld_trn",  longint'(vld2), longint'(exp_vld[2]));
        check("res_trn",  longint'(res2), exp_res[2]);
        check("ovf_trn",  longint'(ovf2), longint'(exp_ov[2]));
    endtask

    task automatic step(input logic r, input logic c, input logic v,
                        input longint a, input longint b, input logic ac);
        reset    = r;
        ce       = c;
        in_valid = v;
        cur_a    = a;
        cur_b    = b;
        dataa    = a[14:0];
        datab    = b[8:0];
        acc      = ac;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        // Reset with ce low still clears the outputs.
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        check("reset_res", longint'(res0), 0);
        check("reset_vld", longint'(vld0), 0);

        // Latency of the default configuration
        step(1'b0, 1'b1, 1'b1, 100, -3, 1'b0);
        idle(1);
        check("lat_early_vld", longint'(vld0), 0);
        check("lat_early_res", longint'(res0), 0);
        idle(1);
        check("lat_vld", longint'(vld0), 1);
        check("lat_res", longint'(res0), -300);
        idle(1);
        check("lat_after_vld", longint'(vld0), 0);

        // Extreme operands
        step(1'b0, 1'b1, 1'b1, -16384, -256, 1'b0);
        idle(2);
        check("ext_min_res", longint'(res0), 4194304);
        check("ext_min_ovf", longint'(ovf0), 0);
        step(1'b0, 1'b1, 1'b1, 16383, 255, 1'b0);
        idle(2);
        check("ext_max_res", longint'(res0), 4177665);

        // Positive saturation, then recovery
        step(1'b0, 1'b1, 1'b1, -16384, -256, 1'b0);
        step(1'b0, 1'b1, 1'b1, -16384, -256, 1'b1);
        step(1'b0, 1'b1, 1'b1, -1, 1, 1'b1);
        idle(1);
        check("sat_pos_res", longint'(res0), 8388607);
        check("sat_pos_ovf", longint'(ovf0), 1);
        idle(1);
        check("sat_dec_res", longint'(res0), 8388606);
        check("sat_dec_ovf", longint'(ovf0), 0);
        idle(2);

        // Negative saturation
        step(1'b0, 1'b1, 1'b1, -16384, 255, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, -16384, 255, 1'b1);
        idle(2);
        check("sat_neg_res", longint'(res0), -8388608);
        check("sat_neg_ovf", longint'(ovf0), 1);
        idle(1);

        // Rounding versus truncation at OUT_WIDTH=16
        step(1'b0, 1'b1, 1'b1, 3, 85, 1'b0);
        idle(3);
        check("round_pos", longint'(res1), 1);
        check("trunc_pos", longint'(res2), 0);
        step(1'b0, 1'b1, 1'b1, -3, 85, 1'b0);
        idle(3);
        check("round_neg", longint'(res1), -1);
        check("trunc_neg", longint'(res2), -1);

        // ce stall: every other cycle frozen, with ignored in_valid while ce=0
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 1000 + k, 7 - k, 1'b0);
            step(1'b0, 1'b0, 1'b1, -5000, 77, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        end

        // Reset mid-stream discards in-flight samples
        step(1'b0, 1'b1, 1'b1, 11, 13, 1'b0);
        step(1'b0, 1'b1, 1'b1, 17, 19, 1'b1);
        step(1'b1, 1'b1, 1'b1, 23, 29, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            check("rst_mid_vld", longint'(vld0), 0);
        end
        check("rst_mid_res", longint'(res0), 0);
        step(1'b0, 1'b1, 1'b1, 7, 9, 1'b1);
        idle(2);
        check("post_rst_res", longint'(res0), 63);

        // Randomised traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                 longint'($urandom_range(0, 32767)) - 16384,
                 longint'($urandom_range(0, 511)) - 256,
                 ($urandom_range(0, 2) != 0));
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
